alu_src_scheduler: RTL and testbench
====================================

// Module: alu_src_scheduler
// PURPOSE
// - Shares the single ALU operand path (ALUSrc1 mux plus ALU) between two requesters.
//   - Requester 0: the core datapath.
//   - Requester 1: the debug/test port.
// - Arbitrates, latches operands, drives the mux select and ALU inputs for the ALU's latency,
//   then returns the result to the winning requester with a valid/ready handshake.
// - Sits between the requesters and MUX1/ALU; it is the only driver of ALUSrc1 and the ALU operands.
// PARAMETERS
// - DATA_W   8  operand/result width
// - OP_W     3  ALU opcode width
// - ALU_LAT  1  cycles from operands applied to alu_result valid; legal 1..15
// PORTS
// - clk          in   1       rising-edge clock
// - reset        in   1       asynchronous, active-high
// - req          in   2       per-requester request; held until matching gnt bit
// - req_a0/a1    in   DATA_W  operand A (ReadData1) from requester 0/1
// - req_b0/b1    in   DATA_W  operand B from requester 0/1
// - req_op0/op1  in   OP_W    ALU opcode from requester 0/1
// - req_zero     in   2       1 = operand A replaced by zero register (ALUSrc1=1)
// - gnt          out  2       one-cycle grant pulse; operands latched this cycle
// - alu_src1     out  1       to MUX1 select
// - alu_a        out  DATA_W  to MUX1 ReadData1 input
// - alu_b        out  DATA_W  to ALU operand B
// - alu_op       out  OP_W    to ALU control
// - alu_result   in   DATA_W  ALU output
// - rsp_valid    out  2       result valid to requester 0/1; one-hot or zero
// - rsp_data     out  DATA_W  captured result
// - rsp_ready    in   2       per-requester accept
// - busy         out  1       1 whenever state != IDLE
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; all outputs 0; last_owner=1, so req0 wins the first tie.
// - FSM: IDLE -> EXEC -> RESP -> IDLE.
// - IDLE:
//   - No req: stay.
//   - Any req: pick winner w; latch that requester's a/b/op/zero; gnt[w]=1 for exactly this cycle;
//     load cnt=ALU_LAT-1; go EXEC.
// - EXEC:
//   - alu_src1, alu_a, alu_b, alu_op driven from latches, stable for the whole state.
//   - cnt!=0: decrement.
//   - cnt==0: rsp_data<=alu_result; go RESP.
// - RESP:
//   - rsp_valid[w]=1 and rsp_data held until rsp_ready[w]=1.
//   - On that cycle: last_owner<=w; go IDLE.
//   - rsp_ready of the non-owner is ignored.
// - ALU outputs keep the last latched values in IDLE/RESP; they are not zeroed.
// - Latency: gnt edge to rsp_valid = ALU_LAT+1 cycles.
// - Throughput: one operation per ALU_LAT+2 cycles with rsp_ready tied high.
//   - No new arbitration on the RESP->IDLE cycle; arbitration happens in IDLE.
// - req dropped in the same cycle as gnt: legal, since operands are already latched.
// - req dropped before gnt: request withdrawn, no effect.
// - req arriving during EXEC/RESP: waits; evaluated in the next IDLE.
// - reset mid-EXEC/RESP: operation aborted; no rsp_valid; result discarded.
// - req_zero=1: alu_src1=1; alu_a still carries the latched A, which MUX1 ignores.
// CONFIGURATION
// - ALU_SCHED_RR_EN defined: round-robin.
//   - On simultaneous req=2'b11, the winner is the requester != last_owner.
// - ALU_SCHED_RR_EN undefined: fixed priority; requester 0 always wins ties.
//   - last_owner is still maintained but not used.
// TESTING
// - Reset: assert reset mid-EXEC -> all outputs 0 immediately; no rsp_valid after release;
//   next req0 granted normally.
// - Single op, ALU_LAT=1: req=01, a0=8'h12, b0=8'h03, op0=ADD
//   -> gnt=01 at T, alu_a=12 at T+1, rsp_valid=01 with rsp_data=8'h15 at T+2.
// - Zero source: req=10, req_zero=10, a1=8'hFF, b1=8'h07
//   -> alu_src1=1 during EXEC; rsp_data=8'h07 (0+7) on rsp_valid=10.
// - Tie, RR_EN defined: req=11 held, rsp_ready=11 -> grant order 0,1,0,1.
//   Same with RR_EN undefined -> 0,0,0.
// - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, busy=1, gnt=0
//   despite pending req1; rsp_ready=1 -> IDLE, then gnt=10 next cycle.
// - ALU_LAT=3: gnt edge to rsp_valid = 4 cycles; operands stable all 3 EXEC cycles.

Source files
------------

// File: rtl/alu_src_scheduler.sv
// alu_src_scheduler
//   Shares the single ALUSrc1 mux + ALU operand path between two requesters
//   (0 = core datapath, 1 = debug/test port). A request is arbitrated in IDLE,
//   its operands are latched and held on the ALU inputs for ALU_LAT cycles
//   (EXEC), and the captured result is returned with a valid/ready handshake
//   (RESP). This block is the only driver of ALUSrc1 and the ALU operands.
//
//   Optional feature macro: ALU_SCHED_RR_EN
//     defined   -> round-robin on a 2'b11 tie (the requester that did not own
//                  the previous operation wins)
//     undefined -> fixed priority, requester 0 wins ties
//
// Ports
//   clk, reset         rising-edge clock, async active-high reset
//   req[1:0]           per-requester request, held until the matching gnt bit
//   req_a0/a1          operand A (ReadData1) per requester
//   req_b0/b1          operand B per requester
//   req_op0/op1        ALU opcode per requester
//   req_zero[1:0]      1 = replace operand A with the zero register (ALUSrc1=1)
//   gnt[1:0]           one-cycle grant; operands are latched in this cycle
//   alu_src1           MUX1 select
//   alu_a, alu_b       ALU operands (alu_a feeds the MUX1 ReadData1 input)
//   alu_op             ALU control
//   alu_result         ALU output, sampled on the last EXEC cycle
//   rsp_valid[1:0]     result valid towards requester 0/1, one-hot or zero
//   rsp_data           captured result
//   rsp_ready[1:0]     per-requester accept
//   busy               high whenever the scheduler is not IDLE

`timescale 1ns/1ps

module alu_src_scheduler #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [1:0]        req_zero,
  output logic [1:0]        gnt,
  output logic              alu_src1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [1:0]        rsp_ready,
  output logic              busy
);

  localparam int CNT_W = 4;

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_check
    $error("alu_src_scheduler: ALU_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // One requester's operation, in the same field order as the ALU-side
  // registers so a single assignment moves a whole slot onto the ALU.
  typedef struct packed {
    logic              zero;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } op_req_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;       // requester of the operation in flight
  logic             last_owner;  // requester of the last completed operation
  logic             win;
  op_req_t [1:0]    slot;

  assign slot[0] = {req_zero[0], req_op0, req_b0, req_a0};
  assign slot[1] = {req_zero[1], req_op1, req_b1, req_a1};

  // Arbitration. Only meaningful while IDLE with at least one request.
  always_comb begin
    win = 1'b0;
`ifdef ALU_SCHED_RR_EN
    if (req == 2'b11) win = ~last_owner;
    else              win = ~req[0];
`else
    win = ~req[0];
`endif
  end

`ifndef ALU_SCHED_RR_EN
  // Fixed priority never consults last_owner; it is still tracked so both
  // builds share identical state and reset behaviour.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // The grant is decided and reported in the same IDLE cycle the operands are
  // latched, so a requester may drop req right after seeing gnt. Gated by
  // reset so that all outputs read zero while reset is asserted.
  assign gnt  = (state == IDLE && !reset && |req) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;        // requester 0 wins the first round-robin tie
      alu_src1   <= 1'b0;
      alu_op     <= '0;
      alu_b      <= '0;
      alu_a      <= '0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner                           <= win;
            {alu_src1, alu_op, alu_b, alu_a} <= slot[win];
            cnt                             <= CNT_W'(ALU_LAT - 1);
            state                           <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs stay on the latched values for the whole state.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= alu_result;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end
        end
        RESP: begin
          // Only the owner's ready completes the handshake. No arbitration
          // on this cycle; the next request is looked at in IDLE.
          if (rsp_ready[owner]) begin
            rsp_valid  <= 2'b00;
            last_owner <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_src_scheduler.sv
`timescale 1ns/1ps

module tb_alu_src_scheduler;

  localparam int LAT = 1;
  localparam bit RR_ON =
`ifdef ALU_SCHED_RR_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, req_zero, rsp_ready, gnt, rsp_valid;
  logic [7:0] a0, a1, b0, b1, alu_a, alu_b, alu_result, rsp_data;
  logic [2:0] op0, op1, alu_op;
  logic       alu_src1, busy;

  // Second instance for the multi-cycle ALU latency check.
  logic       reset3;
  logic [1:0] req3, gnt3, rsp_valid3;
  logic [7:0] a3, b3, alu_a3, alu_b3, alu_result3, rsp_data3;
  logic [2:0] op3, alu_op3;
  logic       alu_src1_3, busy3;

  always #5 clk = ~clk;

  alu_src_scheduler #(.DATA_W(8), .OP_W(3), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
    .req_op0(op0), .req_op1(op1), .req_zero(req_zero),
    .gnt(gnt), .alu_src1(alu_src1), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  alu_src_scheduler #(.DATA_W(8), .OP_W(3), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset3), .req(req3),
    .req_a0(a3), .req_a1(8'h00), .req_b0(b3), .req_b1(8'h00),
    .req_op0(op3), .req_op1(3'd0), .req_zero(2'b00),
    .gnt(gnt3), .alu_src1(alu_src1_3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_result(alu_result3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
    .rsp_ready(2'b11), .busy(busy3)
  );

  // Behavioural MUX1 + ALU.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = a ^ b;
      3'd5:    alu_f = ~(a | b);
      3'd6:    alu_f = b;
      default: alu_f = a;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_op,  alu_src1   ? 8'h00 : alu_a,  alu_b);
  assign alu_result3 = alu_f(alu_op3, alu_src1_3 ? 8'h00 : alu_a3, alu_b3);

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Winner for a request pattern given the previous owner.
  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return RR_ON ? (1 - last) : 0;
    return r[0] ? 0 : 1;
  endfunction

  typedef struct {
    logic [1:0] req;
    logic [1:0] zero;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic [1:0] egnt;
    logic [7:0] edata;
  } vec_t;

  vec_t tbl [9];

  task automatic wait_gnt();
    int n;
    n = 0;
    @(negedge clk);
    while (gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int n;
    @(posedge clk); #1;
    req = v.req; req_zero = v.zero;
    a0 = v.a0; b0 = v.b0; op0 = v.op0;
    a1 = v.a1; b1 = v.b1; op1 = v.op1;
    rsp_ready = 2'b11;
    wait_gnt();
    chk({nm, ".gnt"}, gnt, v.egnt);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    n = 1;
    chk({nm, ".alu_a"}, alu_a, v.egnt[1] ? v.a1 : v.a0);
    chk({nm, ".alu_src1"}, alu_src1, v.egnt[1] ? v.zero[1] : v.zero[0]);
    while (rsp_valid == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".latency"}, n, LAT + 1);
    chk({nm, ".rsp_valid"}, rsp_valid, v.egnt);
    chk({nm, ".rsp_data"}, rsp_data, v.edata);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Scratch for the directed sequences.
  int got [4];
  int at  [4];
  int k, c, bad;

  // Random-phase reference model: an operation's age counts cycles since its
  // grant; EXEC spans ages 1..LAT, the response is up from age LAT+1 on.
  int         m_age, m_own, m_last, m_w;
  logic [7:0] m_a, m_b, m_d;
  logic [2:0] m_op;
  logic       m_z;
  logic [1:0] m_g;

  initial begin
    reset = 1'b1; reset3 = 1'b1;
    req = 2'b11; req_zero = 2'b00; rsp_ready = 2'b00;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0;
    req3 = 2'b00; a3 = '0; b3 = '0; op3 = '0;

    tbl[0] = '{2'b01, 2'b00, 8'h12, 8'h03, 8'h00, 8'h00, 3'd0, 3'd0, 2'b01, 8'h15};
    tbl[1] = '{2'b10, 2'b10, 8'h00, 8'h00, 8'hFF, 8'h07, 3'd0, 3'd0, 2'b10, 8'h07};
    tbl[2] = '{2'b01, 2'b00, 8'h20, 8'h05, 8'h00, 8'h00, 3'd1, 3'd0, 2'b01, 8'h1B};
    tbl[3] = '{2'b10, 2'b00, 8'h00, 8'h00, 8'hF0, 8'h3C, 3'd0, 3'd2, 2'b10, 8'h30};
    tbl[4] = '{2'b01, 2'b01, 8'hAA, 8'h55, 8'h00, 8'h00, 3'd3, 3'd0, 2'b01, 8'h55};
    tbl[5] = '{2'b10, 2'b00, 8'h00, 8'h00, 8'hA5, 8'hFF, 3'd0, 3'd4, 2'b10, 8'h5A};
    tbl[6] = '{2'b01, 2'b00, 8'h80, 8'h80, 8'h00, 8'h00, 3'd0, 3'd0, 2'b01, 8'h00};
    tbl[7] = '{2'b10, 2'b01, 8'h00, 8'h00, 8'h10, 8'h01, 3'd0, 3'd1, 2'b10, 8'h0F};
    tbl[8] = '{2'b01, 2'b10, 8'h10, 8'h01, 8'h00, 8'h00, 3'd1, 3'd0, 2'b01, 8'h0F};

    // Reset state, with both requests asserted during reset.
    repeat (2) @(negedge clk);
    chk("rst.gnt", gnt, 2'b00);
    chk("rst.busy", busy, 1'b0);
    chk("rst.rsp_valid", rsp_valid, 2'b00);
    chk("rst.alu", {alu_src1, alu_op, alu_b, alu_a, rsp_data}, 0);
    @(posedge clk); #1;
    req = 2'b00; reset = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of EXEC aborts the operation.
    @(posedge clk); #1;
    req = 2'b01; req_zero = 2'b00; a0 = 8'h33; b0 = 8'h11; op0 = 3'd1; rsp_ready = 2'b11;
    wait_gnt();
    chk("abort.gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    chk("abort.busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.outs", {rsp_valid, alu_src1, alu_op, alu_b, alu_a}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) bad++;
    end
    chk("abort.no_rsp", bad, 0);
    run_txn(tbl[0], "abort.next");

    // Tie with req=11 held: grant order and back-to-back throughput.
    do_reset();
    req = 2'b11; req_zero = 2'b00; a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    op0 = 3'd0; op1 = 3'd0; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin got[i] = 0; at[i] = 0; end
    k = 0; c = 0;
    while (k < 4 && c < 60) begin
      @(negedge clk);
      c++;
      if (gnt != 2'b00) begin
        got[k] = int'(gnt); at[k] = c; k++;
      end
    end
    @(posedge clk); #1;
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie.order%0d", i), got[i], (RR_ON && (i % 2 == 1)) ? 2 : 1);
      if (i > 0) chk($sformatf("tie.interval%0d", i), at[i] - at[i-1], LAT + 2);
    end
    c = 0;
    while (busy && c < 20) begin @(negedge clk); c++; end

    // Backpressure with a pending request from requester 1.
    @(posedge clk); #1;
    req = 2'b01; a0 = 8'h44; b0 = 8'h22; op0 = 3'd1; rsp_ready = 2'b00;
    wait_gnt();
    chk("bp.gnt0", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b10; a1 = 8'h05; b1 = 8'h06; op1 = 3'd0;
    c = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && c < 20) begin @(negedge clk); c++; end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("bp.valid%0d", i), rsp_valid, 2'b01);
      chk($sformatf("bp.data%0d", i), rsp_data, 8'h22);
      chk($sformatf("bp.busy%0d", i), busy, 1'b1);
      chk($sformatf("bp.gnt%0d", i), gnt, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b10;          // non-owner ready is ignored
    @(negedge clk);
    chk("bp.ignore_other", rsp_valid, 2'b01);
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp.still_resp", rsp_valid, 2'b01);
    @(negedge clk);
    chk("bp.gnt1", gnt, 2'b10);
    chk("bp.idle", busy, 1'b0);
    @(posedge clk); #1;
    req = 2'b00; rsp_ready = 2'b11;
    c = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && c < 20) begin @(negedge clk); c++; end
    chk("bp.rsp1", {rsp_valid, rsp_data}, {2'b10, 8'h0B});

    // ALU_LAT=3: operands stable for 3 EXEC cycles, response 4 cycles after gnt.
    @(posedge clk); #1;
    reset3 = 1'b0;
    @(posedge clk); #1;
    req3 = 2'b01; a3 = 8'h05; b3 = 8'h09; op3 = 3'd0;
    c = 0;
    @(negedge clk);
    while (gnt3 == 2'b00 && c < 20) begin @(negedge clk); c++; end
    chk("lat3.gnt", gnt3, 2'b01);
    @(posedge clk); #1;
    req3 = 2'b00; a3 = 8'hEE; b3 = 8'hDD;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("lat3.exec%0d", i), {busy3, rsp_valid3, alu_op3, alu_b3, alu_a3},
          {1'b1, 2'b00, 3'd0, 8'h09, 8'h05});
    end
    @(negedge clk);
    chk("lat3.rsp", {rsp_valid3, rsp_data3}, {2'b01, 8'h0E});

    // Randomized traffic against the reference model.
    do_reset();
    m_age = -1; m_own = 0; m_last = 1; m_w = 0;
    m_a = '0; m_b = '0; m_d = '0; m_op = '0; m_z = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      req       = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      req_zero  = 2'($urandom_range(0, 3));
      a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom_range(0, 7));
      a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom_range(0, 7));
      @(negedge clk);
      m_g = 2'b00;
      if (m_age < 0 && req != 2'b00) begin
        m_w = pick(req, m_last);
        m_g = (m_w == 1) ? 2'b10 : 2'b01;
      end
      chk("rnd.gnt", gnt, m_g);
      chk("rnd.busy", busy, m_age >= 1);
      chk("rnd.rsp_valid", rsp_valid, (m_age >= LAT + 1) ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00);
      if (m_age >= LAT + 1) chk("rnd.rsp_data", rsp_data, m_d);
      if (m_age >= 1 && m_age <= LAT)
        chk("rnd.alu_in", {alu_src1, alu_op, alu_b, alu_a}, {m_z, m_op, m_b, m_a});
      if (m_g != 2'b00) begin
        m_own = m_w;
        m_a   = (m_w == 1) ? a1 : a0;
        m_b   = (m_w == 1) ? b1 : b0;
        m_op  = (m_w == 1) ? op1 : op0;
        m_z   = req_zero[m_w];
        m_d   = alu_f(m_op, m_z ? 8'h00 : m_a, m_b);
        m_age = 1;
      end else if (m_age >= LAT + 1) begin
        if (rsp_ready[m_own]) begin
          m_last = m_own;
          m_age  = -1;
        end
      end else if (m_age >= 1) begin
        m_age++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
